transmitter_ash: RTL

//   UART transmit engine, the serialiser counterpart of the UART receive path. Accepts
//   one byte per valid/ready handshake and drives TXD with one 11-bit frame:

---
 rtl/transmitter_ash_pkg.sv | 25 ++
 rtl/transmitter_ash_if.sv | 40 ++++
 rtl/transmitter_ash_bit_timer.sv | 29 ++
 rtl/transmitter_ash.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/transmitter_ash_pkg.sv
// Shared UART definitions for the transmit and receive paths.
//   - uart_state_t : frame-sequencing state encoding, common to TX and RX
//   - DEFAULT_OVERSAMPLE / DEFAULT_DATA_BITS / FRAME_BITS : frame geometry
//   - frame_cycles() : clk cycles occupied by one complete frame
package uart_ash_pkg;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned DEFAULT_DATA_BITS  = 8;
    // start + data + parity + stop
    localparam int unsigned FRAME_BITS         = DEFAULT_DATA_BITS + 3;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100
    } uart_state_t;

    function automatic int unsigned frame_cycles(input int unsigned data_bits,
                                                 input int unsigned oversample);
        return (data_bits + 3) * oversample;
    endfunction

endpackage

// File: rtl/transmitter_ash_if.sv
// Byte-source to UART-transmitter bus.
//   TX_Data  : byte to send (host -> tx)
//   Valid_tx : TX_Data valid (host -> tx)
//   Ready_tx : transmitter accepts a byte this cycle (tx -> host)
//   TXD      : serial line, idles high (tx -> pin)
//   Busy     : frame in progress (tx -> host)
//   TX_Done  : one-cycle pulse on the last stop-bit cycle (tx -> host)
// Modports: master = byte source, slave = transmitter.
interface transmitter_ash_if
    import uart_ash_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS
) ();

    logic [DATA_BITS-1:0] TX_Data;
    logic                 Valid_tx;
    logic                 Ready_tx;
    logic                 TXD;
    logic                 Busy;
    logic                 TX_Done;

    modport master (
        output TX_Data,
        output Valid_tx,
        input  Ready_tx,
        input  TXD,
        input  Busy,
        input  TX_Done
    );

    modport slave (
        input  TX_Data,
        input  Valid_tx,
        output Ready_tx,
        output TXD,
        output Busy,
        output TX_Done
    );

endinterface

// File: rtl/transmitter_ash_bit_timer.sv
// uart_bit_timer: oversample counter that delimits serial bit periods.
//   clk        : clock, rising edge
//   clear      : synchronous clear, holds the count at 0
//   sample_cnt : position within the current bit, 0..OVERSAMPLE-1
//   bit_end    : high on the last cycle of a bit (sample_cnt == OVERSAMPLE-1)
// The count wraps to 0 on every bit boundary; shared by the TX and RX paths.
module uart_bit_timer
    import uart_ash_pkg::*;
#(
    parameter  int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    localparam int unsigned CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             clear,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             bit_end
);

    assign bit_end = (sample_cnt == CNT_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (clear || bit_end) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/transmitter_ash.sv
// transmitter_ash: UART transmit engine.
// Serialises one byte per valid/ready handshake into an 11-bit frame
// (start 0, DATA_BITS data LSB first, even parity, stop 1), each bit held
// OVERSAMPLE clk cycles.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; aborts any frame in flight
//   bus   : transmitter_ash_if.slave (TX_Data, Valid_tx, Ready_tx, TXD, Busy, TX_Done)
// Build option: define TX_BUF_EN for a one-entry holding buffer that lets
// the source queue the next byte while a frame is on the line, giving
// gap-free back-to-back frames.
module transmitter_ash
    import uart_ash_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic               clk,
    input  logic               reset,
    transmitter_ash_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic                 parity;
    logic [IDX_W-1:0]     bit_idx;
    logic                 txd;
    logic                 busy;
    logic                 tx_done;

    logic [CNT_W-1:0]     sample_cnt;
    logic                 bit_end;
    logic                 handshake;

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk        (clk),
        .clear      (reset || (state == IDLE)),
        .sample_cnt (sample_cnt),
        .bit_end    (bit_end)
    );

    assign handshake   = bus.Valid_tx && bus.Ready_tx;
    assign bus.TXD     = txd;
    assign bus.Busy    = busy;
    assign bus.TX_Done = tx_done;

`ifdef TX_BUF_EN
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_parity;
    logic                 hold_full;
    logic                 pop_at_stop;

    // On the final stop cycle a full buffer drains into the shift register,
    // so a new byte can be taken in that same cycle.
    assign pop_at_stop  = hold_full && (state == STOP) && bit_end;
    assign bus.Ready_tx = (!hold_full || pop_at_stop) && !reset;
`else
    assign bus.Ready_tx = (state == IDLE) && !reset;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            parity  <= 1'b0;
            bit_idx <= '0;
            txd     <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
`ifdef TX_BUF_EN
            hold_data   <= '0;
            hold_parity <= 1'b0;
            hold_full   <= 1'b0;
`endif
        end else begin
            // Registered pulse: decided one cycle early so it lines up with
            // the last stop-bit cycle.
            tx_done <= (state == STOP) && (sample_cnt == CNT_W'(OVERSAMPLE - 2));

            case (state)
                IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
`ifdef TX_BUF_EN
                    // A byte pushed on the very last stop cycle of an unbuffered
                    // frame lands in the buffer; launch it from here.
                    if (hold_full) begin
                        shift   <= hold_data;
                        parity  <= hold_parity;
                        state   <= START;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                    end else if (handshake) begin
                        shift   <= bus.TX_Data;
                        parity  <= ^bus.TX_Data;
                        state   <= START;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                    end
`else
                    if (handshake) begin
                        shift   <= bus.TX_Data;
                        parity  <= ^bus.TX_Data;
                        state   <= START;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                    end
`endif
                end

                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        txd     <= shift[0];
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state <= PARITY;
                            txd   <= parity;
                        end else begin
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
`ifdef TX_BUF_EN
                        if (hold_full) begin
                            shift  <= hold_data;
                            parity <= hold_parity;
                            state  <= START;
                            txd    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            txd   <= 1'b1;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
                        txd   <= 1'b1;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    txd   <= 1'b1;
                end
            endcase

`ifdef TX_BUF_EN
            // Push has priority over pop so a same-cycle refill keeps it full.
            if (handshake && (state != IDLE)) begin
                hold_data   <= bus.TX_Data;
                hold_parity <= ^bus.TX_Data;
                hold_full   <= 1'b1;
            end else if (hold_full && ((state == IDLE) || pop_at_stop)) begin
                hold_full <= 1'b0;
            end
`endif
        end
    end

endmodule
